// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that gives two clients exclusive, registered access to the
// shared combinational ALU and returns one tagged response per operation.
module alu_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_w,
  input  logic             alu_zero,
  input  logic             alu_neg,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_w,
  output logic             rsp_zero,
  output logic             rsp_neg,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;

  // Requesters gathered into packed arrays so the grant indexes them directly.
  logic [1:0]            vld;
  logic [1:0][WIDTH-1:0] a_in, b_in;
  logic [1:0]            cin_in;
  logic [1:0][OPW-1:0]   op_in;

  assign vld    = {req1_valid, req0_valid};
  assign a_in   = {req1_a, req0_a};
  assign b_in   = {req1_b, req0_b};
  assign cin_in = {req1_cin, req0_cin};
  assign op_in  = {req1_op, req0_op};

  logic        prio;
  logic        gnt;
  logic        accept;
  logic        xfer;
  logic [15:0] ops_cnt;

  // Tie goes to prio; a lone requester wins outright.
  assign gnt    = (vld == 2'b11) ? prio : vld[1];
  assign accept = (state == IDLE) && (|vld) && !rst;
  assign xfer   = (state == RESP) && rsp_ready;

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept &&  gnt;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign ops_done   = ops_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_cin  <= 1'b0;
      alu_op   <= '0;
      rsp_id   <= 1'b0;
      rsp_w    <= '0;
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= a_in[gnt];
        alu_b   <= b_in[gnt];
        alu_cin <= cin_in[gnt];
        alu_op  <= op_in[gnt];
        rsp_id  <= gnt;
        prio    <= ~gnt;
      end
      // ALU settles during EXEC from the operand registers loaded at accept.
      if (state == EXEC) begin
        rsp_w    <= alu_w;
        rsp_zero <= alu_zero;
        rsp_neg  <= alu_neg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       ops_cnt <= '0;
    else if (xfer) ops_cnt <= ops_cnt + 16'd1;
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table of single ops plus hand-written
// backpressure, reset-in-flight, contention and counter-wrap sequences.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_cin = 0, req1_cin = 0;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [15:0] alu_a, alu_b, alu_w;
  logic        alu_cin, alu_zero, alu_neg;
  logic [2:0]  alu_op;
  logic        rsp_valid, rsp_ready = 0, rsp_id, rsp_zero, rsp_neg, busy;
  logic [15:0] rsp_w, ops_done;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_ops = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.WIDTH(16), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_w(rsp_w),
    .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .busy(busy), .ops_done(ops_done)
  );

  // Bench ALU: 0 add-with-carry, 1 subtract, 2 and, others xor.
  always_comb begin
    case (alu_op)
      3'd0:    alu_w = alu_a + alu_b + {15'd0, alu_cin};
      3'd1:    alu_w = alu_a - alu_b;
      3'd2:    alu_w = alu_a & alu_b;
      default: alu_w = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_w == 16'd0);
    alu_neg  = alu_w[15];
  end

  typedef struct {
    logic        v0; logic [15:0] a0, b0; logic c0; logic [2:0] o0;
    logic        v1; logic [15:0] a1, b1; logic c1; logic [2:0] o1;
    logic        g;  logic [15:0] w;      logic z;  logic n;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    chk("rst_alu", {alu_a, alu_b}, 32'd0);
    chk("rst_alu_ctl", {28'd0, alu_cin, alu_op}, 32'd0);
    chk("rst_rsp", {rsp_w, 12'd0, rsp_valid, rsp_id, rsp_zero, rsp_neg}, 32'd0);
    chk("rst_busy_ops", {15'd0, busy, ops_done}, 32'd0);
    rst = 1'b0;
    exp_ops = 16'd0;
  endtask

  task automatic wait_ready(input string nm, output bit ok);
    int n = 0;
    #1;
    while (!(req0_ready || req1_ready) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    ok = (n < 10);
    if (!ok) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    bit ok;
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_cin = v.c0; req0_op = v.o0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_cin = v.c1; req1_op = v.o1;
    rsp_ready  = 1'b1;
    wait_ready(nm, ok);
    if (!ok) begin req0_valid = 0; req1_valid = 0; return; end
    chk({nm, "_grant"}, {30'd0, req1_ready, req0_ready}, v.g ? 32'd2 : 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk({nm, "_alu_ab"}, {alu_a, alu_b}, v.g ? {v.a1, v.b1} : {v.a0, v.b0});
    chk({nm, "_alu_ctl"}, {28'd0, alu_cin, alu_op}, v.g ? {28'd0, v.c1, v.o1} : {28'd0, v.c0, v.o0});
    chk({nm, "_exec"}, {30'd0, busy, rsp_valid}, 32'd2);
    @(posedge clk); #1;
    chk({nm, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({nm, "_rsp"}, {13'd0, rsp_id, rsp_zero, rsp_neg, rsp_w}, {13'd0, v.g, v.z, v.n, v.w});
    @(posedge clk); #1;
    exp_ops = exp_ops + 16'd1;
    chk({nm, "_done"}, {14'd0, busy, rsp_valid, ops_done}, {16'd0, exp_ops});
  endtask

  initial begin
    bit ok;
    tbl[0] = '{1, 16'd100,    16'd2235,   1, 3'd0, 0, 16'd0,     16'd0,     0, 3'd0, 0, 16'd2336,  0, 0};
    tbl[1] = '{0, 16'd0,      16'd0,      0, 3'd0, 1, 16'hFFFF,  16'd1,     0, 3'd0, 1, 16'h0000,  1, 0};
    tbl[2] = '{1, 16'h7FFF,   16'd1,      0, 3'd0, 1, 16'd9,     16'd9,     0, 3'd3, 0, 16'h8000,  0, 1};
    tbl[3] = '{1, 16'h7FFF,   16'd1,      0, 3'd0, 1, 16'd5,     16'd7,     0, 3'd1, 1, 16'hFFFE,  0, 1};
    tbl[4] = '{0, 16'd0,      16'd0,      0, 3'd0, 1, 16'h00F0,  16'h0FF0,  0, 3'd2, 1, 16'h00F0,  0, 0};
    tbl[5] = '{1, 16'd0,      16'd0,      0, 3'd0, 0, 16'd0,     16'd0,     0, 3'd0, 0, 16'h0000,  1, 0};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Backpressure: response held 5 cycles while req1 waits.
    @(negedge clk);
    req0_valid = 1; req0_a = 16'd1; req0_b = 16'd2; req0_cin = 0; req0_op = 3'd0;
    rsp_ready = 0;
    #1 chk("bp_accept0", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'd10; req1_b = 16'd20; req1_cin = 0; req1_op = 3'd0;
    chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d", k), {12'd0, rsp_valid, rsp_id, req1_ready, rsp_zero, rsp_w},
          {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3});
      @(posedge clk); #1;
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    exp_ops = exp_ops + 16'd1;
    chk("bp_idle_accept1", {14'd0, busy, req1_ready, ops_done}, {15'd0, 1'b1, exp_ops});
    @(posedge clk); #1;
    req1_valid = 0;
    chk("bp_alu1", {alu_a, alu_b}, {16'd10, 16'd20});
    @(posedge clk); #1;
    chk("bp_rsp1", {15'd0, rsp_id, rsp_w}, {15'd0, 1'b1, 16'd30});
    @(posedge clk); #1;
    exp_ops = exp_ops + 16'd1;
    chk("bp_ops", {16'd0, ops_done}, {16'd0, exp_ops});

    // Reset during EXEC discards the op and restores prio to 0.
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 16'd4; req0_b = 16'd4; req0_op = 3'd0;
    rsp_ready = 1;
    #1 chk("rx_accept", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rx_quiet%0d", k), {14'd0, rsp_valid, busy, ops_done}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1 chk("rx_prio", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 0; req1_valid = 0;

    // Contention: both valid for four ops, grants must alternate from 0.
    do_reset();
    @(negedge clk);
    req0_valid = 1; req0_a = 16'd100;  req0_b = 16'd2235; req0_cin = 1; req0_op = 3'd0;
    req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'd1;    req1_cin = 0; req1_op = 3'd0;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      wait_ready($sformatf("ct%0d", k), ok);
      if (!ok) break;
      chk($sformatf("ct%0d_grant", k), {30'd0, req1_ready, req0_ready}, (k % 2) ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk($sformatf("ct%0d_rsp", k), {14'd0, rsp_id, rsp_zero, rsp_w},
          (k % 2) ? {14'd0, 1'b1, 1'b1, 16'h0000} : {14'd0, 1'b0, 1'b0, 16'd2336});
      @(posedge clk);
    end
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    exp_ops = 16'd4;
    #1 chk("ct_ops", {16'd0, ops_done}, {16'd0, exp_ops});

    // Counter wrap: preload the count, then one transfer.
    @(negedge clk);
    dut.ops_cnt = 16'hFFFF;
    exp_ops = 16'hFFFF;
    #1 chk("wrap_pre", {16'd0, ops_done}, 32'h0000FFFF);
    run_vec(tbl[0], "wrap");
    chk("wrap_zero", {16'd0, ops_done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
